// File: rtl/mr_wb.sv
// Writeback/retire stage: an id-indexed reorder buffer that gathers out-of-order
// ALU and load/store results and retires them strictly in id order.
module mr_wb #(
  parameter int ID_BITS  = 4,
  parameter int XLEN_P   = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_res_valid,
  output logic                alu_res_ready,
  input  logic [ID_BITS-1:0]  alu_res_id,
  input  logic [REG_BITS-1:0] alu_res_dst,
  input  logic [XLEN_P-1:0]   alu_res_val,
  input  logic                mem_res_valid,
  output logic                mem_res_ready,
  input  logic [ID_BITS-1:0]  mem_res_id,
  input  logic [REG_BITS-1:0] mem_res_dst,
  input  logic [XLEN_P-1:0]   mem_res_val,
  input  logic                flush,
  input  logic [ID_BITS-1:0]  flush_next_id,
  output logic                wb_valid,
  output logic [REG_BITS-1:0] wb_reg,
  output logic [XLEN_P-1:0]   wb_val,
  output logic                retire_valid,
  output logic [ID_BITS-1:0]  retire_id,
  output logic [ID_BITS:0]    occupancy
);
  localparam int DEPTH = 1 << ID_BITS;
  localparam logic [ID_BITS:0] FULL = (ID_BITS+1)'(DEPTH);

  logic [DEPTH-1:0]    slot_valid_reg;
  logic [DEPTH-1:0]    slot_valid_next;
  logic [REG_BITS-1:0] slot_dst [DEPTH];
  logic [XLEN_P-1:0]   slot_val [DEPTH];
  logic [ID_BITS-1:0]  head_reg;
  logic [ID_BITS:0]    occ_next;
  logic                alu_acc, mem_acc, head_ready;

  // On a same-id collision the ALU wins; mem readiness looks at ids, not at alu_res_ready.
  assign alu_res_ready = !rst && !flush && !slot_valid_reg[alu_res_id];
  assign mem_res_ready = !rst && !flush && !slot_valid_reg[mem_res_id] &&
                         !(alu_res_valid && (alu_res_id == mem_res_id));
  assign alu_acc    = alu_res_valid && alu_res_ready;
  assign mem_acc    = mem_res_valid && mem_res_ready;
  assign head_ready = slot_valid_reg[head_reg];

  always_comb begin
    slot_valid_next = slot_valid_reg;
    if (flush) begin
      slot_valid_next = '0;
    end else begin
      if (head_ready) slot_valid_next[head_reg] = 1'b0;
      if (alu_acc)    slot_valid_next[alu_res_id] = 1'b1;
      if (mem_acc)    slot_valid_next[mem_res_id] = 1'b1;
    end
  end

  always_comb begin
    occ_next = occupancy + (ID_BITS+1)'(alu_acc) + (ID_BITS+1)'(mem_acc)
             - (ID_BITS+1)'(head_ready);
  end

  // Payload storage carries no reset; the valid bits alone say what is live.
  always_ff @(posedge clk) begin
    if (alu_acc) begin
      slot_dst[alu_res_id] <= alu_res_dst;
      slot_val[alu_res_id] <= alu_res_val;
    end
    if (mem_acc) begin
      slot_dst[mem_res_id] <= mem_res_dst;
      slot_val[mem_res_id] <= mem_res_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid_reg <= '0;
      head_reg       <= '0;
      wb_valid       <= 1'b0;
      wb_reg         <= '0;
      wb_val         <= '0;
      retire_valid   <= 1'b0;
      retire_id      <= '0;
      occupancy      <= '0;
    end else begin
      slot_valid_reg <= slot_valid_next;
      if (flush) begin
        head_reg     <= flush_next_id;
        wb_valid     <= 1'b0;
        wb_reg       <= '0;
        wb_val       <= '0;
        retire_valid <= 1'b0;
        retire_id    <= '0;
        occupancy    <= '0;
      end else begin
        occupancy <= occ_next;
        if (head_ready) begin
          head_reg     <= head_reg + 1'b1;
          retire_valid <= 1'b1;
          retire_id    <= head_reg;
          wb_valid     <= (slot_dst[head_reg] != '0);
          wb_reg       <= slot_dst[head_reg];
          wb_val       <= slot_val[head_reg];
        end else begin
          retire_valid <= 1'b0;
          wb_valid     <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(alu_acc && slot_valid_reg[alu_res_id]));
      assert (!(mem_acc && slot_valid_reg[mem_res_id]));
      assert (!(alu_acc && mem_acc && (alu_res_id == mem_res_id)));
      assert (occupancy <= FULL);
    end
  end
endmodule

// File: tb/tb_mr_wb.sv
// Directed bench for mr_wb: expected retirements are queued as results are
// offered and matched against the DUT retire/wb outputs after each clock edge.
module tb_mr_wb;
  localparam int IDB = 4;
  localparam int XL  = 32;
  localparam int RB  = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           alu_res_valid, alu_res_ready;
  logic [IDB-1:0] alu_res_id;
  logic [RB-1:0]  alu_res_dst;
  logic [XL-1:0]  alu_res_val;
  logic           mem_res_valid, mem_res_ready;
  logic [IDB-1:0] mem_res_id;
  logic [RB-1:0]  mem_res_dst;
  logic [XL-1:0]  mem_res_val;
  logic           flush;
  logic [IDB-1:0] flush_next_id;
  logic           wb_valid;
  logic [RB-1:0]  wb_reg;
  logic [XL-1:0]  wb_val;
  logic           retire_valid;
  logic [IDB-1:0] retire_id;
  logic [IDB:0]   occupancy;

  mr_wb #(.ID_BITS(IDB), .XLEN_P(XL), .REG_BITS(RB)) dut (
    .clk(clk), .rst(rst),
    .alu_res_valid(alu_res_valid), .alu_res_ready(alu_res_ready),
    .alu_res_id(alu_res_id), .alu_res_dst(alu_res_dst), .alu_res_val(alu_res_val),
    .mem_res_valid(mem_res_valid), .mem_res_ready(mem_res_ready),
    .mem_res_id(mem_res_id), .mem_res_dst(mem_res_dst), .mem_res_val(mem_res_val),
    .flush(flush), .flush_next_id(flush_next_id),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_val(wb_val),
    .retire_valid(retire_valid), .retire_id(retire_id), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDB-1:0] id;
    logic [RB-1:0]  dst;
    logic [XL-1:0]  val;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  logic [IDB-1:0] tb_head = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [IDB-1:0] id, input logic [RB-1:0] dst, input logic [XL-1:0] val);
    exp_t e;
    e.id = id; e.dst = dst; e.val = val;
    sb.push_back(e);
  endtask

  // One clock; any retirement must be the oldest expected id still queued.
  task automatic tick();
    int idx;
    @(posedge clk);
    #1;
    if (retire_valid === 1'b1) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++) if (sb[i].id == tb_head) idx = i;
      chk("retire_known", 64'(idx >= 0), 64'd1);
      chk("retire_id", 64'(retire_id), 64'(tb_head));
      if (idx >= 0) begin
        chk("wb_valid", 64'(wb_valid), 64'(sb[idx].dst != '0));
        chk("wb_reg", 64'(wb_reg), 64'(sb[idx].dst));
        chk("wb_val", 64'(wb_val), 64'(sb[idx].val));
        sb.delete(idx);
      end
      $display("retire id=%0d wb_valid=%0d reg=%0d val=%0h", retire_id, wb_valid, wb_reg, wb_val);
      tb_head++;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_flush(input logic [IDB-1:0] next_id);
    flush = 1'b1;
    flush_next_id = next_id;
    #1;
    chk("flush_alu_ready", 64'(alu_res_ready), 64'd0);
    chk("flush_mem_ready", 64'(mem_res_ready), 64'd0);
    sb.delete();
    tick();
    flush = 1'b0;
    tb_head = next_id;
    chk("flush_retire_valid", 64'(retire_valid), 64'd0);
    chk("flush_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    $display("flush next_id=%0d", next_id);
  endtask

  task automatic alu_offer(input logic [IDB-1:0] id, input logic [RB-1:0] dst, input logic [XL-1:0] val);
    alu_res_valid = 1'b1; alu_res_id = id; alu_res_dst = dst; alu_res_val = val;
  endtask

  task automatic mem_offer(input logic [IDB-1:0] id, input logic [RB-1:0] dst, input logic [XL-1:0] val);
    mem_res_valid = 1'b1; mem_res_id = id; mem_res_dst = dst; mem_res_val = val;
  endtask

  initial begin
    rst = 1'b0;
    alu_res_valid = 0; alu_res_id = '0; alu_res_dst = '0; alu_res_val = '0;
    mem_res_valid = 0; mem_res_id = '0; mem_res_dst = '0; mem_res_val = '0;
    flush = 0; flush_next_id = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_reg", 64'(wb_reg), 64'd0);
    chk("rst_wb_val", 64'(wb_val), 64'd0);
    chk("rst_retire_valid", 64'(retire_valid), 64'd0);
    chk("rst_retire_id", 64'(retire_id), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_alu_ready", 64'(alu_res_ready), 64'd0);
    chk("rst_mem_ready", 64'(mem_res_ready), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Basic: id 0 visible after two edges, no bypass on the first.
    alu_offer(4'd0, 5'd5, 32'h1234);
    #1 chk("t1_alu_ready", 64'(alu_res_ready), 64'd1);
    push(4'd0, 5'd5, 32'h1234);
    tick();
    alu_res_valid = 0;
    chk("t1_no_bypass", 64'(retire_valid), 64'd0);
    chk("t1_occ1", 64'(occupancy), 64'd1);
    tick();
    chk("t1_retired", 64'(retire_valid), 64'd1);
    chk("t1_occ0", 64'(occupancy), 64'd0);

    // Out of order: mem id1 first, ALU id0 three cycles later.
    do_flush(4'd0);
    mem_offer(4'd1, 5'd3, 32'hAA);
    push(4'd1, 5'd3, 32'hAA);
    tick();
    mem_res_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("ooo_wait", 64'(retire_valid), 64'd0);
      tick();
    end
    chk("ooo_occ1", 64'(occupancy), 64'd1);
    alu_offer(4'd0, 5'd4, 32'hBB);
    push(4'd0, 5'd4, 32'hBB);
    tick();
    alu_res_valid = 0;
    chk("ooo_occ2", 64'(occupancy), 64'd2);
    tick();
    chk("ooo_first", 64'(retire_id), 64'd0);
    tick();
    chk("ooo_second", 64'(retire_id), 64'd1);
    chk("ooo_occ0", 64'(occupancy), 64'd0);

    // Store with dst 0 retires without a register write.
    mem_offer(4'd2, 5'd0, 32'h55);
    push(4'd2, 5'd0, 32'h55);
    tick();
    mem_res_valid = 0;
    tick();
    chk("store_retire", 64'(retire_valid), 64'd1);
    chk("store_wb_valid", 64'(wb_valid), 64'd0);

    // Same-id collision at head 6: ALU wins.
    do_flush(4'd6);
    alu_offer(4'd6, 5'd7, 32'h666);
    mem_offer(4'd6, 5'd8, 32'h999);
    #1;
    chk("coll_alu_ready", 64'(alu_res_ready), 64'd1);
    chk("coll_mem_ready", 64'(mem_res_ready), 64'd0);
    push(4'd6, 5'd7, 32'h666);
    tick();
    alu_res_valid = 0; mem_res_valid = 0;
    drain(4);

    // Two accepts in one cycle on distinct ids.
    alu_offer(4'd7, 5'd9, 32'h777);
    mem_offer(4'd8, 5'd10, 32'h888);
    push(4'd7, 5'd9, 32'h777);
    push(4'd8, 5'd10, 32'h888);
    tick();
    alu_res_valid = 0; mem_res_valid = 0;
    chk("dual_occ2", 64'(occupancy), 64'd2);
    drain(4);

    // Wrap: ids 14,15,0,1 streamed back to back.
    do_flush(4'd14);
    for (int k = 0; k < 4; k++) begin
      alu_offer(IDB'(14 + k), RB'(k + 1), 32'h1400 + 32'(k));
      push(IDB'(14 + k), RB'(k + 1), 32'h1400 + 32'(k));
      tick();
    end
    alu_res_valid = 0;
    drain(8);
    chk("wrap_head", 64'(tb_head), 64'd2);

    // Flush with three entries buffered behind an empty head.
    for (int k = 4; k < 7; k++) begin
      alu_offer(IDB'(k), 5'd1, 32'(k));
      tick();
    end
    alu_res_valid = 0;
    chk("pre_flush_occ3", 64'(occupancy), 64'd3);
    do_flush(4'd9);
    alu_offer(4'd9, 5'd11, 32'h9999);
    push(4'd9, 5'd11, 32'h9999);
    tick();
    alu_res_valid = 0;
    drain(4);

    // Asynchronous reset mid-stream while a retire is showing.
    alu_offer(4'd11, 5'd2, 32'hB0B);
    tick();
    alu_offer(4'd10, 5'd1, 32'h10);
    push(4'd10, 5'd1, 32'h10);
    tick();
    alu_res_valid = 0;
    tick();
    chk("pre_rst_retire", 64'(retire_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_retire_valid", 64'(retire_valid), 64'd0);
    chk("arst_wb_valid", 64'(wb_valid), 64'd0);
    chk("arst_wb_reg", 64'(wb_reg), 64'd0);
    chk("arst_wb_val", 64'(wb_val), 64'd0);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_alu_ready", 64'(alu_res_ready), 64'd0);
    sb.delete();
    tb_head = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 64'(retire_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
